// File: rtl/pitch_estimate_smoother_if.sv
// Frame-rate bus between the HPS stage, the pitch smoother and the shift-ratio logic.
interface pitch_estimate_smoother_if #(
  parameter int unsigned K_WIDTH = 11
);
  logic [K_WIDTH-1:0] k_in;
  logic               k_in_valid;
  logic [K_WIDTH-1:0] k_out;
  logic               k_out_valid;
  logic               locked;

  // Producer of raw bins / consumer of smoothed bins
  modport master (
    output k_in, k_in_valid,
    input  k_out, k_out_valid, locked
  );

  // The smoother itself
  modport slave (
    input  k_in, k_in_valid,
    output k_out, k_out_valid, locked
  );
endinterface

// File: rtl/pitch_estimate_smoother.sv
// Pitch estimate smoother: 5-tap median over voiced frames followed by a
// jump-confirmation FSM; a run of unvoiced frames unlocks and clears it.
module pitch_estimate_smoother #(
  parameter int unsigned K_WIDTH       = 11,
  parameter int unsigned JUMP_TOL      = 2,
  parameter int unsigned HOLD_COUNT    = 3,
  parameter int unsigned SILENCE_LIMIT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  pitch_estimate_smoother_if.slave  bus
);

  localparam int unsigned HistDepth = 5;
  localparam int unsigned HcntW     = $clog2(HOLD_COUNT + 1);
  localparam int unsigned SilW      = $clog2(SILENCE_LIMIT + 1);

  typedef logic [K_WIDTH-1:0] bin_t;
  typedef enum logic [1:0] {StIdle, StTrack, StCand} state_e;

  function automatic bin_t min2(input bin_t a, input bin_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic bin_t max2(input bin_t a, input bin_t b);
    return (a < b) ? b : a;
  endfunction

  // One extra bit so the subtraction cannot wrap
  function automatic logic [K_WIDTH:0] abs_diff(input bin_t a, input bin_t b);
    logic [K_WIDTH:0] ae;
    logic [K_WIDTH:0] be;
    ae = {1'b0, a};
    be = {1'b0, b};
    return (ae >= be) ? (ae - be) : (be - ae);
  endfunction

  // Front end: history, fill and silence tracking
  bin_t [HistDepth-1:0] hist_q, hist_d, win;
  logic [2:0]           fill_q, fill_d;
  logic [SilW-1:0]      sil_q, sil_d;
  logic                 start, unlock;

  // Median pipeline
  bin_t [HistDepth-1:0] s1_q, s1_d;
  bin_t                 p_q, p_d, q_q, q_d, r_q, r_d, med_q, med_d;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  // Decision stage
  state_e               state_q, state_d;
  bin_t                 k_out_q, k_out_d, cand_q, cand_d;
  logic [HcntW-1:0]     hcnt_q, hcnt_d;
  logic                 kv_q, kv_d, locked_q, locked_d;
  logic                 near_out, near_cand;

  // History write, fill saturation and silence counting; unlock fires once per silent run
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    sil_d  = sil_q;
    start  = 1'b0;
    unlock = 1'b0;
    win    = {hist_q[HistDepth-2:0], bus.k_in};
    if (bus.k_in_valid) begin
      if (bus.k_in != '0) begin
        hist_d = win;
        sil_d  = '0;
        if (fill_q < 3'(HistDepth)) fill_d = fill_q + 3'd1;
        start = (fill_q >= 3'(HistDepth - 1));
      end else if (sil_q < SilW'(SILENCE_LIMIT)) begin
        sil_d  = sil_q + SilW'(1);
        unlock = (sil_q == SilW'(SILENCE_LIMIT - 1));
      end
    end
    if (unlock) begin
      hist_d = '0;
      fill_d = '0;
    end
  end

  // Median-of-5 network: sort two pairs, drop the global min/max candidates, median of three
  always_comb begin
    s1_d[0] = min2(win[0], win[1]);
    s1_d[1] = max2(win[0], win[1]);
    s1_d[2] = min2(win[2], win[3]);
    s1_d[3] = max2(win[2], win[3]);
    s1_d[4] = win[4];
    p_d     = max2(s1_q[0], s1_q[2]);
    q_d     = min2(s1_q[1], s1_q[3]);
    r_d     = s1_q[4];
    med_d   = max2(min2(p_q, q_q), min2(max2(p_q, q_q), r_q));
    // An unlock kills everything still travelling down the pipe
    v1_d    = start;
    v2_d    = v1_q & ~unlock;
    v3_d    = v2_q & ~unlock;
  end

  // Jump-confirmation FSM and output update
  always_comb begin
    state_d   = state_q;
    k_out_d   = k_out_q;
    cand_d    = cand_q;
    hcnt_d    = hcnt_q;
    locked_d  = locked_q;
    kv_d      = 1'b0;
    near_out  = abs_diff(med_q, k_out_q) <= (K_WIDTH + 1)'(JUMP_TOL);
    near_cand = abs_diff(med_q, cand_q) <= (K_WIDTH + 1)'(JUMP_TOL);
    if (unlock) begin
      state_d  = StIdle;
      k_out_d  = '0;
      cand_d   = '0;
      hcnt_d   = '0;
      locked_d = 1'b0;
      kv_d     = 1'b1;
    end else if (v3_q) begin
      kv_d = 1'b1;
      unique case (state_q)
        StIdle: begin
          k_out_d  = med_q;
          locked_d = 1'b1;
          state_d  = StTrack;
        end
        StTrack: begin
          if (near_out) begin
            k_out_d = med_q;
          end else begin
            cand_d  = med_q;
            hcnt_d  = HcntW'(1);
            state_d = StCand;
          end
        end
        StCand: begin
          if (near_out) begin
            k_out_d = med_q;
            state_d = StTrack;
          end else if (near_cand) begin
            cand_d = med_q;
            hcnt_d = hcnt_q + HcntW'(1);
            if (hcnt_q + HcntW'(1) == HcntW'(HOLD_COUNT)) begin
              k_out_d = med_q;
              state_d = StTrack;
            end
          end else begin
            cand_d = med_q;
            hcnt_d = HcntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q   <= '0;
      fill_q   <= '0;
      sil_q    <= '0;
      s1_q     <= '0;
      p_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      med_q    <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      state_q  <= StIdle;
      k_out_q  <= '0;
      cand_q   <= '0;
      hcnt_q   <= '0;
      kv_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      sil_q    <= sil_d;
      s1_q     <= s1_d;
      p_q      <= p_d;
      q_q      <= q_d;
      r_q      <= r_d;
      med_q    <= med_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      state_q  <= state_d;
      k_out_q  <= k_out_d;
      cand_q   <= cand_d;
      hcnt_q   <= hcnt_d;
      kv_q     <= kv_d;
      locked_q <= locked_d;
    end
  end

  assign bus.k_out       = k_out_q;
  assign bus.k_out_valid = kv_q;
  assign bus.locked      = locked_q;

endmodule

// File: tb/tb_pitch_estimate_smoother.sv
// Directed bench for pitch_estimate_smoother; inputs driven on the falling edge,
// outputs sampled on the falling edge.
module tb_pitch_estimate_smoother;

  logic clock;
  logic reset;
  int   total;
  int   passes;
  int   fails;

  pitch_estimate_smoother_if #(.K_WIDTH(11)) bus ();

  pitch_estimate_smoother #(
    .K_WIDTH      (11),
    .JUMP_TOL     (2),
    .HOLD_COUNT   (3),
    .SILENCE_LIMIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called and returns on a falling edge
  task automatic do_reset(input string tag);
    bus.k_in       = '0;
    bus.k_in_valid = 1'b0;
    reset          = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check({tag, "_valid"}, bus.k_out_valid, 0);
    check({tag, "_kout"}, bus.k_out, 0);
    check({tag, "_locked"}, bus.locked, 0);
  endtask

  // Voiced frame: pulse (if any) must appear on the 4th falling edge after the drive
  task automatic frame(input string tag, input int k, input bit exp_pulse,
                       input int exp_k, input bit exp_lock);
    bus.k_in       = 11'(k);
    bus.k_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (i == 1) begin
        bus.k_in_valid = 1'b0;
        bus.k_in       = '0;
      end
      if (i < 4) begin
        check({tag, "_early"}, bus.k_out_valid, 0);
      end else begin
        check({tag, "_valid"}, bus.k_out_valid, 32'(exp_pulse));
        if (exp_pulse) begin
          check({tag, "_kout"}, bus.k_out, exp_k);
          check({tag, "_locked"}, bus.locked, 32'(exp_lock));
        end
      end
    end
  endtask

  // Unvoiced frame: the unlock pulse comes one cycle after the strobe
  task automatic zero_frame(input string tag, input bit exp_pulse);
    bus.k_in       = '0;
    bus.k_in_valid = 1'b1;
    @(negedge clock);
    bus.k_in_valid = 1'b0;
    check({tag, "_valid"}, bus.k_out_valid, 32'(exp_pulse));
    if (exp_pulse) begin
      check({tag, "_kout"}, bus.k_out, 0);
      check({tag, "_locked"}, bus.locked, 0);
    end
  endtask

  task automatic lock40(input string tag);
    do_reset({tag, "_rst"});
    for (int i = 0; i < 4; i++) frame({tag, "_fill"}, 40, 1'b0, 0, 1'b0);
    frame({tag, "_lock"}, 40, 1'b1, 40, 1'b1);
  endtask

  initial begin
    int t3_exp[7];
    int t4_in[11];
    int t4_exp[11];
    total          = 0;
    passes         = 0;
    fails          = 0;
    reset          = 1'b1;
    bus.k_in       = '0;
    bus.k_in_valid = 1'b0;
    @(negedge clock);

    // 1: first lock after five frames of 40
    lock40("t1");

    // 2: isolated octave error rejected by the median
    frame("t2_a", 80, 1'b1, 40, 1'b1);
    frame("t2_b", 40, 1'b1, 40, 1'b1);
    frame("t2_c", 40, 1'b1, 40, 1'b1);

    // 3: real jump accepted on the third agreeing median
    t3_exp = '{40, 40, 40, 40, 60, 60, 60};
    lock40("t3");
    for (int i = 0; i < 7; i++) frame("t3_jump", 60, 1'b1, t3_exp[i], 1'b1);

    // 4: drift of exactly JUMP_TOL tracked directly; a step of JUMP_TOL+1 needs confirmation
    t4_in  = '{42, 42, 42, 44, 44, 44, 47, 47, 47, 47, 47};
    t4_exp = '{40, 40, 42, 42, 42, 44, 44, 44, 44, 44, 47};
    lock40("t4");
    for (int i = 0; i < 11; i++) frame("t4_drift", t4_in[i], 1'b1, t4_exp[i], 1'b1);

    // 5: silence unlock, single pulse, then a full refill before relocking
    for (int i = 0; i < 3; i++) zero_frame("t5_quiet", 1'b0);
    zero_frame("t5_unlock", 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t5_no_stale", bus.k_out_valid, 0);
    end
    zero_frame("t5_extra_zero", 1'b0);
    for (int i = 0; i < 4; i++) frame("t5_refill", 50, 1'b0, 0, 1'b0);
    frame("t5_relock", 50, 1'b1, 50, 1'b1);

    // 6: reset coincident with a strobe while a median is in flight
    lock40("t6");
    bus.k_in       = 11'd40;
    bus.k_in_valid = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset          = 1'b0;
    bus.k_in_valid = 1'b0;
    bus.k_in       = '0;
    for (int i = 0; i < 5; i++) begin
      check("t6_no_pulse", bus.k_out_valid, 0);
      @(negedge clock);
    end
    check("t6_kout", bus.k_out, 0);
    check("t6_locked", bus.locked, 0);
    for (int i = 0; i < 4; i++) frame("t6_refill", 40, 1'b0, 0, 1'b0);
    frame("t6_relock", 40, 1'b1, 40, 1'b1);

    // 7: back-to-back strobes
    do_reset("t7_rst");
    for (int i = 0; i < 5; i++) begin
      bus.k_in       = 11'(30 + i);
      bus.k_in_valid = 1'b1;
      @(negedge clock);
      check("t7_quiet_in", bus.k_out_valid, 0);
    end
    bus.k_in_valid = 1'b0;
    bus.k_in       = '0;
    repeat (2) begin
      @(negedge clock);
      check("t7_quiet_after", bus.k_out_valid, 0);
    end
    @(negedge clock);
    check("t7_valid", bus.k_out_valid, 1);
    check("t7_kout", bus.k_out, 32);
    check("t7_locked", bus.locked, 1);
    @(negedge clock);
    check("t7_single", bus.k_out_valid, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
